// File: rtl/dmi_pkg.sv
// Shared DMI definitions: response-op encodings and a small index-width helper.
package dmi_pkg;

   localparam logic [1:0] DMI_OP_SUCCESS = 2'b00;
   localparam logic [1:0] DMI_OP_FAILED  = 2'b10;
   localparam logic [1:0] DMI_OP_BUSY    = 2'b11;

   // Bits needed to index n entries, never less than one.
   function automatic int unsigned dmi_idx_width(input int unsigned n);
      if (n > 32'd1) begin
         return $clog2(n);
      end else begin
         return 32'd1;
      end
   endfunction

endpackage

// File: rtl/dmi_sync_fifo.sv
// Single-clock registered FIFO (no fall-through).
// The pointers carry one extra wrap bit. Full means the wrap bits differ and the indices match.
// Empty means the pointers are equal. The index wraps explicitly at DEPTH-1, so any DEPTH >= 1 works.
module dmi_sync_fifo
   import dmi_pkg::*;
#(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [DW-1:0] wdata_i,
   input  logic          pop_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o
);

   localparam int unsigned AW = dmi_idx_width(DEPTH);

   logic [AW:0]   wptr_q, wptr_d;
   logic [AW:0]   rptr_q, rptr_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic          push_en_s, pop_en_s;

   // Advance a pointer by one, toggling the wrap bit when the index rolls over.
   function automatic logic [AW:0] ptr_next(input logic [AW:0] p);
      if (p[AW-1:0] == AW'(DEPTH - 1)) begin
         return {~p[AW], {AW{1'b0}}};
      end else begin
         return p + {{AW{1'b0}}, 1'b1};
      end
   endfunction

   assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign empty_o   = (wptr_q == rptr_q);
   assign push_en_s = push_i && !full_o;
   assign pop_en_s  = pop_i && !empty_o;
   assign rdata_o   = mem_q[rptr_q[AW-1:0]];

   // Next-pointer selection for accepted pushes and pops.
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push_en_s) begin
         wptr_d = ptr_next(wptr_q);
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_en_s) begin
         rptr_d = ptr_next(rptr_q);
      end else begin
         rptr_d = rptr_q;
      end
   end

   // Pointer registers and storage; reset clears everything so data outputs read 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (push_en_s) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
         end
      end
   end

endmodule

// File: rtl/dmi_req_buffer.sv
// Core-domain DMI request buffer: request queue, in-flight credit limit, in-order response queue.
// Optional feature macro DMI_TIMEOUT_EN: synthesises a FAILED response when the DM stays silent
// and swallows the late DM response that eventually follows.
module dmi_req_buffer
   import dmi_pkg::*;
#(
   parameter int unsigned REQUEST_DW      = 41,
   parameter int unsigned RESPONSE_DW     = 34,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic                                   clk_i,
   input  logic                                   rst_ni,
   input  logic                                   up_req_valid_i,
   input  logic [REQUEST_DW-1:0]                  up_req_i,
   output logic                                   up_req_ready_o,
   output logic                                   up_resp_valid_o,
   output logic [RESPONSE_DW-1:0]                 up_resp_o,
   input  logic                                   up_resp_ready_i,
   output logic                                   dn_req_valid_o,
   output logic [REQUEST_DW-1:0]                  dn_req_o,
   input  logic                                   dn_req_ready_i,
   input  logic                                   dn_resp_valid_i,
   input  logic [RESPONSE_DW-1:0]                 dn_resp_i,
   output logic                                   dn_resp_ready_o,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
   output logic                                   timeout_o
);

   localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

   logic                   req_full_s, req_empty_s;
   logic                   resp_full_s, resp_empty_s;
   logic                   dn_req_hs_s, up_resp_hs_s;
   logic                   resp_push_s;
   logic [RESPONSE_DW-1:0] resp_wdata_s;
   logic [OW-1:0]          outstanding_q, outstanding_d;

   dmi_sync_fifo #(.DW(REQUEST_DW), .DEPTH(DEPTH)) u_req_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (up_req_valid_i),
      .wdata_i (up_req_i),
      .pop_i   (dn_req_hs_s),
      .rdata_o (dn_req_o),
      .full_o  (req_full_s),
      .empty_o (req_empty_s)
   );

   dmi_sync_fifo #(.DW(RESPONSE_DW), .DEPTH(MAX_OUTSTANDING)) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (resp_push_s),
      .wdata_i (resp_wdata_s),
      .pop_i   (up_resp_ready_i),
      .rdata_o (up_resp_o),
      .full_o  (resp_full_s),
      .empty_o (resp_empty_s)
   );

   assign up_req_ready_o  = !req_full_s;
   assign dn_req_valid_o  = !req_empty_s && (outstanding_q < OW'(MAX_OUTSTANDING));
   assign dn_req_hs_s     = dn_req_valid_o && dn_req_ready_i;
   assign up_resp_valid_o = !resp_empty_s;
   assign up_resp_hs_s    = up_resp_valid_o && up_resp_ready_i;
   assign outstanding_o   = outstanding_q;

   // In-flight count: issue adds a credit, upstream consumption returns one.
   always_comb begin
      outstanding_d = outstanding_q;
      case ({dn_req_hs_s, up_resp_hs_s})
         2'b10:   outstanding_d = outstanding_q + {{(OW-1){1'b0}}, 1'b1};
         2'b01:   outstanding_d = outstanding_q - {{(OW-1){1'b0}}, 1'b1};
         default: outstanding_d = outstanding_q;
      endcase
   end

   // Credit counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         outstanding_q <= '0;
      end else begin
         outstanding_q <= outstanding_d;
      end
   end

`ifdef DMI_TIMEOUT_EN
   localparam int unsigned TW = dmi_idx_width(TIMEOUT_CYCLES);

   logic [OW-1:0] pend_q, pend_d;     // issued to DM, not yet answered (real or synthetic)
   logic [TW-1:0] wait_q, wait_d;
   logic [7:0]    drop_q, drop_d;     // late DM responses still to be swallowed
   logic          timeout_q;
   logic          real_s, discard_s, fire_s;

   assign discard_s       = dn_resp_valid_i && (drop_q != 8'd0);
   assign real_s          = dn_resp_valid_i && (drop_q == 8'd0) && !resp_full_s;
   assign fire_s          = (pend_q != '0) && (wait_q == TW'(TIMEOUT_CYCLES - 1)) && !real_s;
   assign resp_push_s     = real_s || fire_s;
   assign resp_wdata_s    = fire_s ? {{(RESPONSE_DW-2){1'b0}}, DMI_OP_FAILED} : dn_resp_i;
   assign dn_resp_ready_o = (drop_q != 8'd0) || !resp_full_s;
   assign timeout_o       = timeout_q;

   // Timeout bookkeeping: pending count, wait counter and drop counter.
   always_comb begin
      pend_d = pend_q;
      wait_d = wait_q;
      drop_d = drop_q;
      case ({dn_req_hs_s, resp_push_s})
         2'b10:   pend_d = pend_q + {{(OW-1){1'b0}}, 1'b1};
         2'b01:   pend_d = pend_q - {{(OW-1){1'b0}}, 1'b1};
         default: pend_d = pend_q;
      endcase
      if (resp_push_s || (pend_q == '0)) begin
         wait_d = '0;
      end else begin
         wait_d = wait_q + {{(TW-1){1'b0}}, 1'b1};
      end
      case ({fire_s, discard_s})
         2'b10:   drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
         2'b01:   drop_d = drop_q - 8'd1;
         default: drop_d = drop_q;
      endcase
   end

   // Timeout state registers; timeout_o is the registered fire pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pend_q    <= '0;
         wait_q    <= '0;
         drop_q    <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         pend_q    <= pend_d;
         wait_q    <= wait_d;
         drop_q    <= drop_d;
         timeout_q <= fire_s;
      end
   end
`else
   logic unused_timeout_s;

   assign unused_timeout_s = (TIMEOUT_CYCLES > 32'd0);
   assign resp_push_s      = dn_resp_valid_i && !resp_full_s;
   assign resp_wdata_s     = dn_resp_i;
   assign dn_resp_ready_o  = !resp_full_s;
   assign timeout_o        = 1'b0;
`endif

endmodule
